// File: rtl/max_if.sv
// Candidate/result bundle for the Needleman-Wunsch maximum selector.
// master drives the request and the three scores; slave returns the registered result.
interface max_if #(
   parameter int WIDTH = 9
);
   logic                    value;
   logic signed [WIDTH-1:0] diag;
   logic signed [WIDTH-1:0] up;
   logic signed [WIDTH-1:0] lx;
   logic signed [WIDTH-1:0] max;
   logic        [2:0]       symbol;
   logic                    calculated;

   modport master (
      output value, diag, up, lx,
      input  max, symbol, calculated
   );

   modport slave (
      input  value, diag, up, lx,
      output max, symbol, calculated
   );
endinterface

// File: rtl/max.sv
// Scoring-cell maximum selector: registers the signed max of diag/up/lx plus traceback flags.
// Optional MAX_SINGLE_DIR_EN makes symbol one-hot with priority diag > up > lx.
module max #(
   parameter int WIDTH = 9
) (
   input  logic   clk,
   input  logic   rst,
   max_if.slave   bus
);

   logic signed [WIDTH-1:0] best_du;
   logic signed [WIDTH-1:0] best;
   logic        [2:0]       hit;
   logic        [2:0]       dir;

   // NOTE: every always_comb output is assigned a default first so no latch is inferred.
   always_comb begin
      best_du = bus.up;
      best    = bus.lx;
      hit     = 3'b000;
      dir     = 3'b000;

      if (bus.diag >= bus.up) best_du = bus.diag;
      if (best_du >= bus.lx)  best    = best_du;

      // The winner always equals at least one candidate, so hit is never zero.
      hit = {bus.diag == best, bus.up == best, bus.lx == best};

`ifdef MAX_SINGLE_DIR_EN
      if (hit[2])      dir = 3'b100;
      else if (hit[1]) dir = 3'b010;
      else             dir = 3'b001;
`else
      dir = hit;
`endif
   end

   // NOTE: state registers use non-blocking assignments so all outputs update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.max        <= '0;
         bus.symbol     <= 3'b000;
         bus.calculated <= 1'b0;
      end else begin
         bus.calculated <= bus.value;
         if (bus.value) begin
            bus.max    <= best;
            bus.symbol <= dir;
         end
      end
   end

endmodule

// File: tb/tb_max.sv
// Directed self-checking bench for max: reset, ordering, ties, hold, extremes, streaming.
module tb_max;
   localparam int WIDTH = 9;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   max_if #(.WIDTH(WIDTH)) bus ();

   max #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [8:0] exp_max,
                            input logic [2:0] exp_sym, input logic exp_cal);
      check({tag, ".max"},        {23'b0, bus.max},        {23'b0, exp_max});
      check({tag, ".symbol"},     {29'b0, bus.symbol},     {29'b0, exp_sym});
      check({tag, ".calculated"}, {31'b0, bus.calculated}, {31'b0, exp_cal});
   endtask

   // Drive on the falling edge, let one rising edge capture, sample 1 time unit later.
   task automatic step(input logic v, input logic [8:0] d, input logic [8:0] u, input logic [8:0] l);
      @(negedge clk);
      bus.value = v;
      bus.diag  = d;
      bus.up    = u;
      bus.lx    = l;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] sym_tie2;
      logic [2:0] sym_tie3;
`ifdef MAX_SINGLE_DIR_EN
      sym_tie2 = 3'b100;
      sym_tie3 = 3'b100;
`else
      sym_tie2 = 3'b110;
      sym_tie3 = 3'b111;
`endif

      // Reset with an active request and arbitrary inputs.
      rst       = 1'b1;
      bus.value = 1'b1;
      bus.diag  = 9'($urandom);
      bus.up    = 9'($urandom);
      bus.lx    = 9'($urandom);
      #1;
      check_out("reset", 9'h000, 3'b000, 1'b0);
      @(posedge clk);
      #1;
      check_out("reset_held", 9'h000, 3'b000, 1'b0);

      @(negedge clk);
      rst       = 1'b0;
      bus.value = 1'b0;

      step(1'b1, 9'h1FC, 9'h1FE, 9'h1FD);
      check_out("basic", 9'h1FE, 3'b010, 1'b1);

      step(1'b1, 9'd5, 9'd5, 9'h1FF);
      check_out("tie_diag_up", 9'd5, sym_tie2, 1'b1);

      step(1'b1, 9'd0, 9'd0, 9'd0);
      check_out("tie_all", 9'd0, sym_tie3, 1'b1);

      step(1'b0, 9'd7, 9'd1, 9'd2);
      check_out("hold", 9'd0, sym_tie3, 1'b0);

      step(1'b1, 9'h100, 9'h0FF, 9'h000);
      check_out("ext_pos", 9'h0FF, 3'b010, 1'b1);

      step(1'b1, 9'h100, 9'h100, 9'h101);
      check_out("ext_neg", 9'h101, 3'b001, 1'b1);

      // Input change between edges must not reach the outputs.
      @(negedge clk);
      bus.diag = 9'd100;
      bus.up   = 9'd90;
      bus.lx   = 9'd80;
      #1;
      check_out("between_edges", 9'h101, 3'b001, 1'b1);

      step(1'b1, 9'h1CE, 9'h1CE, 9'd10);
      check_out("b2b_lx", 9'd10, 3'b001, 1'b1);
      step(1'b1, 9'd20, 9'h1CE, 9'h1CE);
      check_out("b2b_diag", 9'd20, 3'b100, 1'b1);
      step(1'b1, 9'h1CE, 9'd30, 9'h1CE);
      check_out("b2b_up", 9'd30, 3'b010, 1'b1);

      // Mid-operation reset between edges with value still high.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_out("reset_mid", 9'h000, 3'b000, 1'b0);

      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 9'd3, 9'd3, 9'd3);
      check_out("after_reset", 9'd3, sym_tie3, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
